// File: rtl/max_min_pkg.sv
// Shared types for the streaming max/min tracker: FSM state encoding and
// the index-width helper used to size the sample counter and index outputs.
package max_min_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   function automatic int idx_width(input int count);
      return (count < 2) ? 1 : $clog2(count);
   endfunction

endpackage

// File: rtl/max_min_cmp.sv
// Combinational magnitude compare of two samples, unsigned or two's-complement
// depending on SIGNED. Values are compared at their native width.
module max_min_cmp #(
   parameter int WIDTH  = 8,
   parameter int SIGNED = 0
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             a_gt_b,
   output logic             a_lt_b
);

   // signedness is a static choice; both branches are pure compares
   always_comb begin
      a_gt_b = 1'b0;
      a_lt_b = 1'b0;
      if (SIGNED != 0) begin
         a_gt_b = ($signed(a) > $signed(b));
         a_lt_b = ($signed(a) < $signed(b));
      end else begin
         a_gt_b = (a > b);
         a_lt_b = (a < b);
      end
   end

endmodule

// File: rtl/stream_max_min_tracker.sv
// Frame-based running max/min tracker: accepts COUNT samples on a valid/ready
// input, then holds one result beat (values plus first-occurrence indices).
module stream_max_min_tracker
   import max_min_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int COUNT  = 16,
   parameter int SIGNED = 0,
   localparam int IDXW  = idx_width(COUNT)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] max_val,
   output logic [WIDTH-1:0] min_val,
   output logic [IDXW-1:0]  max_idx,
   output logic [IDXW-1:0]  min_idx,
   output logic             busy
);

   state_t          state_r;
   logic [IDXW-1:0] cnt_r;
   logic            new_gt_max_s;
   logic            new_lt_min_s;
   logic [1:0]      cmp_unused_s;

   max_min_cmp #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cmp_max (
      .a      (in_data),
      .b      (max_val),
      .a_gt_b (new_gt_max_s),
      .a_lt_b (cmp_unused_s[0])
   );

   max_min_cmp #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cmp_min (
      .a      (in_data),
      .b      (min_val),
      .a_gt_b (cmp_unused_s[1]),
      .a_lt_b (new_lt_min_s)
   );

   // frame FSM, sample counter and result registers; handshake flags are
   // registered alongside the state so they always match it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         cnt_r     <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         max_val   <= '0;
         min_val   <= '0;
         max_idx   <= '0;
         min_idx   <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_r  <= ACCUM;
                  cnt_r    <= '0;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            ACCUM: begin
               // an abort wins over a sample offered in the same cycle
               if (start) begin
                  cnt_r <= '0;
               end else if (in_valid) begin
                  if (cnt_r == '0) begin
                     max_val <= in_data;
                     min_val <= in_data;
                     max_idx <= '0;
                     min_idx <= '0;
                  end else begin
                     if (new_gt_max_s) begin
                        max_val <= in_data;
                        max_idx <= cnt_r;
                     end
                     if (new_lt_min_s) begin
                        min_val <= in_data;
                        min_idx <= cnt_r;
                     end
                  end
                  if (cnt_r == IDXW'(COUNT - 1)) begin
                     state_r   <= HOLD;
                     cnt_r     <= '0;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end else begin
                     cnt_r <= cnt_r + IDXW'(1);
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_r   <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state_r   <= IDLE;
               cnt_r     <= '0;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stream_max_min_tracker.sv
// Bench for stream_max_min_tracker: an unsigned and a signed instance share
// stimulus; results are checked against a first-occurrence max/min model.
module tb_stream_max_min_tracker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] in_data = 8'd0;

   logic       ir_uns, ov_uns, busy_uns, ir_sgn, ov_sgn, busy_sgn;
   logic [7:0] mxv_uns, mnv_uns, mxv_sgn, mnv_sgn;
   logic [1:0] mxi_uns, mni_uns, mxi_sgn, mni_sgn;

   int tests = 0;
   int fails = 0;
   logic [7:0] smp [4];

   stream_max_min_tracker #(.WIDTH(8), .COUNT(4), .SIGNED(0)) dut_uns (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(ir_uns),
      .in_data(in_data), .out_valid(ov_uns), .out_ready(out_ready), .max_val(mxv_uns),
      .min_val(mnv_uns), .max_idx(mxi_uns), .min_idx(mni_uns), .busy(busy_uns)
   );

   stream_max_min_tracker #(.WIDTH(8), .COUNT(4), .SIGNED(1)) dut_sgn (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(ir_sgn),
      .in_data(in_data), .out_valid(ov_sgn), .out_ready(out_ready), .max_val(mxv_sgn),
      .min_val(mnv_sgn), .max_idx(mxi_sgn), .min_idx(mni_sgn), .busy(busy_sgn)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int val(input logic [7:0] x, input bit sg);
      return sg ? int'($signed(x)) : int'({24'd0, x});
   endfunction

   // reference: extreme value first, then the first position holding it
   task automatic ref_model(input bit sg, output logic [7:0] mx, output int mxi,
                            output logic [7:0] mn, output int mni);
      int hi, lo;
      hi = val(smp[0], sg);
      lo = val(smp[0], sg);
      for (int i = 1; i < 4; i++) begin
         if (val(smp[i], sg) > hi) hi = val(smp[i], sg);
         if (val(smp[i], sg) < lo) lo = val(smp[i], sg);
      end
      mxi = -1;
      mni = -1;
      for (int i = 0; i < 4; i++) begin
         if (mxi < 0 && val(smp[i], sg) == hi) mxi = i;
         if (mni < 0 && val(smp[i], sg) == lo) mni = i;
      end
      mx = smp[mxi];
      mn = smp[mni];
   endtask

   task automatic check_zero(input string tag);
      check({tag, "/uns_flags"}, 32'({ir_uns, ov_uns, busy_uns}), 32'd0);
      check({tag, "/sgn_flags"}, 32'({ir_sgn, ov_sgn, busy_sgn}), 32'd0);
      check({tag, "/uns_data"}, 32'({mxv_uns, mnv_uns, mxi_uns, mni_uns}), 32'd0);
      check({tag, "/sgn_data"}, 32'({mxv_sgn, mnv_sgn, mxi_sgn, mni_sgn}), 32'd0);
   endtask

   task automatic check_result(input string tag);
      logic [7:0] mx, mn;
      int mxi, mni;
      ref_model(1'b0, mx, mxi, mn, mni);
      check({tag, "/uns_ov"}, 32'({ov_uns, ir_uns, busy_uns}), 32'b101);
      check({tag, "/uns_max"}, 32'({mxv_uns, mxi_uns}), 32'({mx, mxi[1:0]}));
      check({tag, "/uns_min"}, 32'({mnv_uns, mni_uns}), 32'({mn, mni[1:0]}));
      ref_model(1'b1, mx, mxi, mn, mni);
      check({tag, "/sgn_ov"}, 32'({ov_sgn, ir_sgn, busy_sgn}), 32'b101);
      check({tag, "/sgn_max"}, 32'({mxv_sgn, mxi_sgn}), 32'({mx, mxi[1:0]}));
      check({tag, "/sgn_min"}, 32'({mnv_sgn, mni_sgn}), 32'({mn, mni[1:0]}));
   endtask

   task automatic do_start(input string tag);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "/accum"}, 32'({ir_uns, busy_uns, ov_uns, ir_sgn}), 32'b1101);
   endtask

   task automatic feed_frame(input string tag, input int maxgap);
      for (int i = 0; i < 4; i++) begin
         repeat ((maxgap > 0) ? $urandom_range(maxgap, 0) : 0) begin
            in_valid = 1'b0;
            @(negedge clk);
         end
         in_valid = 1'b1;
         in_data  = smp[i];
         if (i == 3) check({tag, "/ov_before_last"}, 32'({ov_uns, ov_sgn}), 32'd0);
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "/drained"}, 32'({ov_uns, busy_uns, ov_sgn, busy_sgn}), 32'd0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // 1: unsigned basic, back-to-back
      smp = '{8'd5, 8'd200, 8'd3, 8'd17};
      do_start("t1");
      feed_frame("t1", 0);
      check_result("t1");
      check("t1/const", 32'({mxv_uns, mxi_uns, mnv_uns, mni_uns}), 32'({8'd200, 2'd1, 8'd3, 2'd2}));
      drain("t1");

      // 2: signed ordering
      smp = '{8'h80, 8'h7F, 8'hFF, 8'h00};
      do_start("t2");
      feed_frame("t2", 0);
      check_result("t2");
      check("t2/const", 32'({mxv_sgn, mxi_sgn, mnv_sgn, mni_sgn}), 32'({8'h7F, 2'd1, 8'h80, 2'd0}));
      drain("t2");
      repeat (2) @(negedge clk);
      check("t2/idle_keep", 32'({mxv_sgn, mnv_sgn}), 32'({8'h7F, 8'h80}));

      // 3: ties keep earliest index
      smp = '{8'd9, 8'd9, 8'd1, 8'd1};
      do_start("t3");
      feed_frame("t3", 0);
      check_result("t3");
      check("t3/const", 32'({mxi_uns, mni_uns}), 32'({2'd0, 2'd2}));
      drain("t3");

      // 4: backpressure with start held in HOLD
      smp = '{8'd50, 8'd60, 8'd40, 8'd70};
      do_start("t4");
      feed_frame("t4", 0);
      start = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("t4/hold%0d", k),
               32'({ov_uns, ir_uns, busy_uns, mxv_uns, mxi_uns, mnv_uns, mni_uns}),
               32'({3'b101, 8'd70, 2'd3, 8'd40, 2'd2}));
      end
      start = 1'b0;
      drain("t4");

      // 5: abort after two samples; sample alongside start is discarded
      do_start("t5");
      in_valid = 1'b1; in_data = 8'd1;  @(negedge clk);
      in_data = 8'd250;                 @(negedge clk);
      start = 1'b1; in_data = 8'd5;     @(negedge clk);
      start = 1'b0; in_valid = 1'b0;
      smp = '{8'd10, 8'd20, 8'd30, 8'd40};
      feed_frame("t5", 0);
      check_result("t5");
      check("t5/const", 32'({mxv_uns, mxi_uns, mnv_uns, mni_uns}), 32'({8'd40, 2'd3, 8'd10, 2'd0}));
      drain("t5");

      // 6: reset mid-frame, then a clean frame
      do_start("t6");
      in_valid = 1'b1; in_data = 8'd250; @(negedge clk);
      in_data = 8'd251;                  @(negedge clk);
      in_valid = 1'b0; rst_n = 1'b0;     @(negedge clk);
      check_zero("t6_rst");
      rst_n = 1'b1;
      smp = '{8'd3, 8'd1, 8'd4, 8'd1};
      do_start("t6b");
      feed_frame("t6b", 0);
      check_result("t6b");
      check("t6b/const", 32'({mxv_uns, mxi_uns, mnv_uns, mni_uns}), 32'({8'd4, 2'd2, 8'd1, 2'd1}));
      drain("t6b");

      // random frames with input gaps and output stalls
      for (int f = 0; f < 12; f++) begin
         for (int i = 0; i < 4; i++) smp[i] = 8'($urandom_range(255, 0));
         if (f[0]) smp[$urandom_range(3, 0)] = smp[$urandom_range(3, 0)];
         do_start($sformatf("rnd%0d", f));
         feed_frame($sformatf("rnd%0d", f), 3);
         repeat ($urandom_range(3, 0)) @(negedge clk);
         check_result($sformatf("rnd%0d", f));
         drain($sformatf("rnd%0d", f));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
